// File: rtl/mac_unit.sv
// Unsigned multiply-accumulate: combinational partial-product array multiplier
// feeding a wrap-around accumulator with a sticky overflow flag.
module mac_unit #(
    parameter int A_WIDTH   = 7,
    parameter int B_WIDTH   = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [A_WIDTH-1:0]           A,
    input  logic [B_WIDTH-1:0]           B,
    input  logic                         acc_en,
    input  logic                         acc_clr,
    output logic [A_WIDTH+B_WIDTH-1:0]   Result,
    output logic [ACC_WIDTH-1:0]         Acc,
    output logic                         acc_ovf
);

    localparam int P_W = A_WIDTH + B_WIDTH;

    generate
        if (ACC_WIDTH < P_W) begin : g_bad_acc_width
            $error("mac_unit: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
        end
    endgenerate

    // Each row adds one shifted partial product onto the running sum of the rows above.
    genvar j;
    generate
        for (j = 0; j < B_WIDTH; j++) begin : g_row
            logic [P_W-1:0] pp;
            logic [P_W-1:0] sum;
            assign pp = {{B_WIDTH{1'b0}}, A & {A_WIDTH{B[j]}}} << j;
            if (j == 0) begin : g_first
                assign sum = pp;
            end else begin : g_add
                assign sum = g_row[j-1].sum + pp;
            end
        end
    endgenerate

    assign Result = g_row[B_WIDTH-1].sum;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum_w;

    // One extra bit captures the carry out of the accumulator.
    assign sum_w = {1'b0, acc_q} + (ACC_WIDTH+1)'(Result);

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (acc_clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (acc_en) begin
            acc_d = sum_w[ACC_WIDTH-1:0];
            ovf_d = ovf_q | sum_w[ACC_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign Acc     = acc_q;
    assign acc_ovf = ovf_q;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: scoreboard of expected Acc/acc_ovf values
// pushed when a cycle is driven and popped after the DUT edge.
module tb_mac_unit;

    localparam int A_WIDTH   = 7;
    localparam int B_WIDTH   = 4;
    localparam int ACC_WIDTH = 16;
    localparam int P_W       = A_WIDTH + B_WIDTH;
    localparam longint ACC_MOD = longint'(1) << ACC_WIDTH;

    logic                 clk;
    logic                 rst_n;
    logic [A_WIDTH-1:0]   A;
    logic [B_WIDTH-1:0]   B;
    logic                 acc_en;
    logic                 acc_clr;
    logic [P_W-1:0]       Result;
    logic [ACC_WIDTH-1:0] Acc;
    logic                 acc_ovf;

    mac_unit #(
        .A_WIDTH  (A_WIDTH),
        .B_WIDTH  (B_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .acc_en (acc_en),
        .acc_clr(acc_clr),
        .Result (Result),
        .Acc    (Acc),
        .acc_ovf(acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint acc;
        logic   ovf;
    } exp_t;

    exp_t   sb[$];
    longint model_acc;
    logic   model_ovf;
    int     checks;
    int     errors;

    task automatic model_reset();
        model_acc = 0;
        model_ovf = 1'b0;
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic cycle(input logic en, input logic clr, input string name);
        exp_t e;
        exp_t got;
        longint s;
        acc_en  = en;
        acc_clr = clr;
        if (clr) begin
            model_acc = 0;
            model_ovf = 1'b0;
        end else if (en) begin
            s = model_acc + longint'(A) * longint'(B);
            if (s >= ACC_MOD) begin
                s = s - ACC_MOD;
                model_ovf = 1'b1;
            end
            model_acc = s;
        end
        e.acc = model_acc;
        e.ovf = model_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        if (Acc !== got.acc[ACC_WIDTH-1:0]) begin
            errors++;
            $display("FAIL %s acc: got %0d expected %0d", name, Acc, got.acc);
        end
        checks++;
        if (acc_ovf !== got.ovf) begin
            errors++;
            $display("FAIL %s ovf: got %0b expected %0b", name, acc_ovf, got.ovf);
        end
        acc_en  = 1'b0;
        acc_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; A = '0; B = '0; acc_en = 1'b0; acc_clr = 1'b0;
        #12;
        checks++;
        if (Acc !== '0 || acc_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got acc=%0d ovf=%0b expected acc=0 ovf=0", Acc, acc_ovf);
        end
    endtask

    task automatic test_product();
        int a_t[3] = '{0, 127, 1};
        int b_t[3] = '{9, 15, 1};
        int r_t[3] = '{0, 1905, 1};
        for (int i = 0; i < 3; i++) begin
            A = A_WIDTH'(a_t[i]);
            B = B_WIDTH'(b_t[i]);
            #10;
            checks++;
            if (Result !== P_W'(r_t[i])) begin
                errors++;
                $display("FAIL product_fixed A=%0d B=%0d: got %0d expected %0d", a_t[i], b_t[i], Result, r_t[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            int a, b;
            rst_n = (i >= 20);
            a = $urandom_range(0, (1 << A_WIDTH) - 1);
            b = $urandom_range(0, (1 << B_WIDTH) - 1);
            A = A_WIDTH'(a);
            B = B_WIDTH'(b);
            #10;
            checks++;
            if (Result !== P_W'(a * b)) begin
                errors++;
                $display("FAIL product_rand A=%0d B=%0d rst_n=%0b: got %0d expected %0d", a, b, rst_n, Result, a * b);
            end
        end
    endtask

    // Reset then align to just after a rising edge so cycle() drives mid-period.
    task automatic restart();
        rst_n = 1'b0;
        acc_en = 1'b0;
        acc_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_accumulate();
        restart();
        A = 7'd10; B = 4'd3;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, "accumulate");
            checks++;
            if (Result !== P_W'(30)) begin
                errors++;
                $display("FAIL accumulate_result: got %0d expected 30", Result);
            end
        end
    endtask

    task automatic test_wrap();
        restart();
        A = 7'd127; B = 4'd15;
        for (int i = 0; i < 34; i++) cycle(1'b1, 1'b0, "wrap_run");
        checks++;
        if (Acc !== 16'd64770 || acc_ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_edge34: got acc=%0d ovf=%0b expected acc=64770 ovf=0", Acc, acc_ovf);
        end
        cycle(1'b1, 1'b0, "wrap_edge35");
        checks++;
        if (Acc !== 16'd1139 || acc_ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_edge35: got acc=%0d ovf=%0b expected acc=1139 ovf=1", Acc, acc_ovf);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "wrap_hold");
    endtask

    task automatic test_clear_priority();
        cycle(1'b1, 1'b1, "clear_priority");
        checks++;
        if (Acc !== '0 || acc_ovf !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority_abs: got acc=%0d ovf=%0b expected acc=0 ovf=0", Acc, acc_ovf);
        end
    endtask

    task automatic test_async_reset();
        restart();
        A = 7'd5; B = 4'd5;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "async_prefill");
        checks++;
        if (Acc !== 16'd75) begin
            errors++;
            $display("FAIL async_prefill_abs: got %0d expected 75", Acc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (Acc !== '0 || acc_ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: got acc=%0d ovf=%0b expected acc=0 ovf=0", Acc, acc_ovf);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, "async_release");
        checks++;
        if (Acc !== 16'd25) begin
            errors++;
            $display("FAIL async_release_abs: got %0d expected 25", Acc);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            int a, b;
            a = $urandom_range(0, (1 << A_WIDTH) - 1);
            b = $urandom_range(0, (1 << B_WIDTH) - 1);
            A = A_WIDTH'(a);
            B = B_WIDTH'(b);
            cycle(1'b0, 1'b0, "hold");
            checks++;
            if (Result !== P_W'(a * b)) begin
                errors++;
                $display("FAIL hold_result A=%0d B=%0d: got %0d expected %0d", a, b, Result, a * b);
            end
        end
    endtask

    task automatic test_back_to_back();
        restart();
        for (int i = 0; i < 20; i++) begin
            A = A_WIDTH'($urandom_range(0, (1 << A_WIDTH) - 1));
            B = B_WIDTH'($urandom_range(0, (1 << B_WIDTH) - 1));
            cycle(1'b1, (i == 10), "back_to_back");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_product();
        test_accumulate();
        test_wrap();
        test_clear_priority();
        test_async_reset();
        test_hold();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
